// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional signed output is enabled by defining BCD2BIN_SIGN_EN.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned BIN_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     bcd_in,
`ifdef BCD2BIN_SIGN_EN
    input  logic                    sign_in,
`endif
    output logic                    busy,
    output logic                    done,
`ifdef BCD2BIN_SIGN_EN
    output logic [BIN_WIDTH:0]      bin_out,
`else
    output logic [BIN_WIDTH-1:0]    bin_out,
`endif
    output logic                    err_digit,
    output logic                    overflow
);

`ifdef BCD2BIN_SIGN_EN
    localparam int unsigned OUT_W = BIN_WIDTH + 1;
`else
    localparam int unsigned OUT_W = BIN_WIDTH;
`endif
    localparam int unsigned DIG_W = 4 * DIGITS;
    localparam int unsigned TOT_W = DIG_W + BIN_WIDTH;
    localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIG_W-1:0]   dig_q;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OUT_W-1:0]   bin_out_q;
    logic               err_q;
    logic               ovf_q;
`ifdef BCD2BIN_SIGN_EN
    logic               sign_q;
`endif

    logic               accept;
    logic               bad_digit;
    logic               last_iter;
    logic [TOT_W-1:0]   shifted;
    logic [DIG_W-1:0]   dig_next;
    logic [BIN_WIDTH-1:0] bin_next;
    logic               resid_nz;
    logic [OUT_W-1:0]   result;

    function automatic logic any_bad(input logic [DIG_W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9)
                bad = 1'b1;
        end
        return bad;
    endfunction

    // Per-digit correction after the shift; each nibble is adjusted on its own.
    function automatic logic [DIG_W-1:0] correct(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] r;
        r = d;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd8)
                r[4*i +: 4] = d[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    assign accept    = start && (state_q != SHIFT);
    assign bad_digit = any_bad(bcd_in);
    assign last_iter = (cnt_q == CNT_W'(BIN_WIDTH - 1));
    assign shifted   = {dig_q, bin_q} >> 1;
    assign dig_next  = correct(shifted[TOT_W-1:BIN_WIDTH]);
    assign bin_next  = shifted[BIN_WIDTH-1:0];
    assign resid_nz  = |dig_next;

`ifdef BCD2BIN_SIGN_EN
    logic [OUT_W-1:0] magnitude;
    always_comb begin
        magnitude = {1'b0, resid_nz ? {BIN_WIDTH{1'b1}} : bin_next};
        result    = sign_q ? ((~magnitude) + OUT_W'(1)) : magnitude;
    end
`else
    assign result = resid_nz ? '1 : bin_next;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = bad_digit ? DONE : SHIFT;
            end
            SHIFT: begin
                if (last_iter)
                    state_d = DONE;
            end
            DONE: begin
                if (accept)
                    state_d = bad_digit ? DONE : SHIFT;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
            sign_q    <= 1'b0;
`endif
        end else if (accept) begin
            dig_q <= bcd_in;
            bin_q <= '0;
            cnt_q <= '0;
            err_q <= bad_digit;
            ovf_q <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
            sign_q <= sign_in;
`endif
            if (bad_digit)
                bin_out_q <= '0;
        end else if (state_q == SHIFT) begin
            dig_q <= dig_next;
            bin_q <= bin_next;
            cnt_q <= cnt_q + CNT_W'(1);
            // Result is captured on the same edge that enters DONE.
            if (last_iter) begin
                ovf_q     <= resid_nz;
                bin_out_q <= result;
            end
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign bin_out   = bin_out_q;
    assign err_digit = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (8-bit and 10-bit instances).
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy8, done8, err8, ovf8;
    logic [7:0]  bin8;
    logic        busy10, done10, err10, ovf10;
    logic [9:0]  bin10;

    int checks = 0;
    int errors = 0;
    int lat;
    int nbusy;
    int k;
    int seen_done;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy8), .done(done8), .bin_out(bin8),
        .err_digit(err8), .overflow(ovf8)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_WIDTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy10), .done(done10), .bin_out(bin10),
        .err_digit(err10), .overflow(ovf10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count cycles (1 = first cycle after accept) until done.
    task automatic run(input logic [11:0] v, output int lat_o, output int busy_o);
        repeat (3) @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        lat_o  = 1;
        busy_o = 0;
        while (!done8 && lat_o < 40) begin
            if (busy8) busy_o++;
            @(posedge clk); #1;
            lat_o++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #12;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_bin",  32'(bin8),  32'd0);
        check("rst_err",  32'(err8),  32'd0);
        check("rst_ovf",  32'(ovf8),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 255 -> FF, no overflow
        run(12'h255, lat, nbusy);
        check("t1_lat",  32'(lat),   32'd9);
        check("t1_busy", 32'(nbusy), 32'd8);
        check("t1_bin",  32'(bin8),  32'hFF);
        check("t1_ovf",  32'(ovf8),  32'd0);
        check("t1_err",  32'(err8),  32'd0);
        @(posedge clk); #1;
        check("t1_done_w", 32'(done8), 32'd0);
        check("t1_hold",   32'(bin8),  32'hFF);

        run(12'h042, lat, nbusy);
        check("t2a_lat", 32'(lat),  32'd9);
        check("t2a_bin", 32'(bin8), 32'h2A);
        @(posedge clk); #1;
        check("t2a_done_w", 32'(done8), 32'd0);

        run(12'h000, lat, nbusy);
        check("t2b_lat", 32'(lat),  32'd9);
        check("t2b_bin", 32'(bin8), 32'h00);
        @(posedge clk); #1;
        check("t2b_done_w", 32'(done8), 32'd0);

        // 999 overflows 8 bits but fits in 10
        run(12'h999, lat, nbusy);
        check("t3_lat", 32'(lat),  32'd9);
        check("t3_ovf", 32'(ovf8), 32'd1);
        check("t3_bin", 32'(bin8), 32'hFF);
        k = 0;
        while (!done10 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("t3_w10_lat", 32'(k),     32'd2);
        check("t3_w10_bin", 32'(bin10), 32'd999);
        check("t3_w10_ovf", 32'(ovf10), 32'd0);

        // invalid digit: immediate done, no SHIFT
        run(12'h1A3, lat, nbusy);
        check("t4_lat",  32'(lat),   32'd1);
        check("t4_busy", 32'(nbusy), 32'd0);
        check("t4_bsy2", 32'(busy8), 32'd0);
        check("t4_err",  32'(err8),  32'd1);
        check("t4_bin",  32'(bin8),  32'd0);
        check("t4_ovf",  32'(ovf8),  32'd0);
        @(posedge clk); #1;
        check("t4_done_w", 32'(done8), 32'd0);

        // start mid-SHIFT ignored, then held high into DONE for back-to-back
        repeat (3) @(negedge clk);
        bcd_in = 12'h128;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        bcd_in = 12'h999;
        start  = 1'b1;
        @(posedge clk); #1;
        lat++;
        start  = 1'b0;
        check("t5_err_clr", 32'(err8), 32'd0);
        repeat (3) begin @(posedge clk); #1; lat++; end
        bcd_in = 12'h017;
        start  = 1'b1;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t5a_lat", 32'(lat),  32'd9);
        check("t5a_bin", 32'(bin8), 32'h80);
        check("t5a_ovf", 32'(ovf8), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_done_w", 32'(done8), 32'd0);
        check("t5_b2b",    32'(busy8), 32'd1);
        lat = 1;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t5b_lat", 32'(lat),  32'd9);
        check("t5b_bin", 32'(bin8), 32'h11);

        // reset mid-conversion aborts with no done
        repeat (3) @(negedge clk);
        bcd_in = 12'h200;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy8), 32'd0);
        check("t6_done", 32'(done8), 32'd0);
        check("t6_bin",  32'(bin8),  32'd0);
        check("t6_err",  32'(err8),  32'd0);
        check("t6_ovf",  32'(ovf8),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen_done++;
        end
        check("t6_no_done", 32'(seen_done), 32'd0);
        run(12'h200, lat, nbusy);
        check("t6_lat", 32'(lat),  32'd9);
        check("t6_c8",  32'(bin8), 32'hC8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: one right-shift plus digit correction per clock.
It is the inverse of the binary-to-BCD path attached to the ROM readout. It turns operator-entered decimal digits, such as switch or keypad BCD, back into a binary address or data word.
It uses a start/done handshake and holds its result until the next accepted start.

Parameters:
DIGITS, 3, number of 4-bit BCD digits on bcd_in
BIN_WIDTH, 8, binary result width; also the number of shift iterations

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; accepted only when busy=0
bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled on the accepted start edge
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when the result is valid
bin_out  output  BIN_WIDTH  converted value, held until the next accepted start
err_digit  output  1  some input digit was >9; held with the result
overflow  output  1  decimal value > 2^BIN_WIDTH-1; held with the result

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, err_digit and overflow = 0; bin_out=0; internal shift registers and counter = 0.
  - Reset mid-SHIFT aborts the conversion with no done pulse.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 on a rising edge while in IDLE or DONE.
  - bcd_in is latched into the digit register; the bin shift register is cleared; iteration counter = 0.
  - err_digit and overflow are cleared.
- Digit check on accept: any digit >9 →
  - err_digit=1, bin_out=0, next state DONE; SHIFT is skipped.
  - done asserts on the clock edge after the accept.
- SHIFT, once per cycle:
  - Shift the concatenation {digits, bin} right by 1; the digit-0 LSB enters the bin MSB.
  - Then each digit that is ≥8 has 3 subtracted (4-bit, no borrow across digits).
  - The counter increments; after BIN_WIDTH iterations the next state is DONE.
- Entering DONE, result handling:
  - Residual digit register ≠0 → overflow=1, bin_out saturates to all ones.
  - Otherwise bin_out = bin shift register.
  - done=1 for exactly the one cycle the FSM is in DONE; next state IDLE unless start is accepted.
- Latency: accept edge to done high = BIN_WIDTH+1 clocks for a valid input; 1 clock for err_digit.
- start while busy=1: ignored. No queueing and no effect on the current conversion.
- start during DONE: accepted (back-to-back). The done pulse is still exactly one cycle and the FSM goes straight to SHIFT.
- bcd_in may change freely after the accept edge.
- Arithmetic: all unsigned; digit correction confined to 4-bit fields.
- Correctness range: any valid BCD value 0..10^DIGITS-1.

Optional Feature:
- Macro: BCD2BIN_SIGN_EN.
- When defined:
  - Adds input sign_in (1 bit), latched with bcd_in on accept.
  - bin_out widens to BIN_WIDTH+1 bits, two's complement.
  - In DONE a negative sign negates the magnitude; negative zero yields 0.
  - Overflow saturates to +(2^BIN_WIDTH-1) or -(2^BIN_WIDTH-1) according to sign.
  - err_digit behaviour is unchanged; the error result is 0.
  - Latency is unchanged.
- When not defined: no sign_in port; unsigned BIN_WIDTH-bit output exactly as described above.

Test Plan:
1. Defaults, bcd_in=12'h255, start pulse → busy for 8 cycles; done on cycle 9 after accept; bin_out=8'hFF, overflow=0, err_digit=0.
2. bcd_in=12'h042 → bin_out=8'h2A; then bcd_in=12'h000 → bin_out=8'h00. Both with done exactly one cycle wide.
3. bcd_in=12'h999 → overflow=1, bin_out=8'hFF, done after 9 cycles. With BIN_WIDTH=10 the same input gives bin_out=10'd999, overflow=0.
4. bcd_in=12'h1A3 → done one cycle after accept; err_digit=1, bin_out=0, busy never high.
5. Start with 12'h128, pulse start again mid-SHIFT (ignored) → bin_out=8'h80. Hold start high through done with bcd_in=12'h017 → back-to-back conversion; second done gives 8'h11.
6. Start 12'h200, drop rst_n at iteration 4 → all outputs 0 immediately and no done pulse. After release, 12'h200 converts to 8'hC8.
